// File: rtl/fix_field_tokenizer.sv
// FIX tag=value<SOH> tokenizer sitting behind the 32-bit message FIFO.
// Unpacks words MSB-first, decodes the decimal tag and streams value bytes with a one-byte holdback.
module fix_field_tokenizer #(
    parameter int DATA_WIDTH  = 32,
    parameter int TAG_WIDTH   = 16,
    parameter int MAX_VAL_LEN = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_rd_en_o,
    output logic                  fifo_rd_cs_o,
    input  logic                  out_ready_i,
    output logic                  tag_valid_o,
    output logic [TAG_WIDTH-1:0]  tag_o,
    output logic                  val_valid_o,
    output logic [7:0]            val_data_o,
    output logic                  val_last_o,
    output logic                  msg_end_o,
    output logic                  err_o
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int ACC_W  = TAG_WIDTH + 4;
    localparam int CNT_W  = $clog2(MAX_VAL_LEN + 2);
    localparam logic [7:0]       SOH     = 8'h01;
    localparam logic [7:0]       EQ      = 8'h3D;
    localparam logic [ACC_W-1:0] TAG_MAX = ACC_W'((1 << TAG_WIDTH) - 1);

    typedef enum logic [1:0] {S_TAG, S_VAL, S_ERR} state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   buf_q;
    logic                    buf_valid_q;
    logic [1:0]              idx_q;
    logic                    rd_pend_q;
    logic [TAG_WIDTH-1:0]    acc_q;
    logic                    seen_digit_q;
    logic [7:0]              held_q;
    logic                    held_valid_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [TAG_WIDTH-1:0]    cur_tag_q;
    logic                    tag_valid_q, val_valid_q, val_last_q, msg_end_q, err_q;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic [7:0]              val_data_q;

    logic [7:0]       lane [NBYTES];
    logic [7:0]       cur_byte;
    logic [7:0]       digit;
    logic [ACC_W-1:0] acc_mul;
    logic             is_digit, tag_ovf, stall, consume, last_byte;

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign lane[gi] = buf_q[DATA_WIDTH-1-8*gi -: 8];
        end
    endgenerate

    assign cur_byte  = lane[idx_q];
    assign digit     = cur_byte - 8'h30;
    assign is_digit  = (cur_byte >= 8'h30) && (cur_byte <= 8'h39);
    assign acc_mul   = ACC_W'(acc_q) * ACC_W'(10) + ACC_W'(digit[3:0]);
    assign tag_ovf   = acc_mul > TAG_MAX;
    assign stall     = (tag_valid_q | val_valid_q) & ~out_ready_i;
    assign consume   = buf_valid_q & ~stall;
    assign last_byte = (idx_q == 2'(NBYTES - 1));

    // Refill only once the current word is used up, so at most one word is ever in flight.
    assign fifo_rd_en_o = rst & ~fifo_empty_i & ~rd_pend_q & ~stall &
                          (~buf_valid_q | (consume & last_byte));
    assign fifo_rd_cs_o = fifo_rd_en_o;

    assign tag_valid_o = tag_valid_q;
    assign tag_o       = tag_q;
    assign val_valid_o = val_valid_q;
    assign val_data_o  = val_data_q;
    assign val_last_o  = val_last_q;
    assign msg_end_o   = msg_end_q;
    assign err_o       = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_TAG;
            buf_q        <= '0;
            buf_valid_q  <= 1'b0;
            idx_q        <= '0;
            rd_pend_q    <= 1'b0;
            acc_q        <= '0;
            seen_digit_q <= 1'b0;
            held_q       <= '0;
            held_valid_q <= 1'b0;
            cnt_q        <= '0;
            cur_tag_q    <= '0;
            tag_valid_q  <= 1'b0;
            tag_q        <= '0;
            val_valid_q  <= 1'b0;
            val_data_q   <= '0;
            val_last_q   <= 1'b0;
            msg_end_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rd_pend_q <= fifo_rd_en_o;
            err_q     <= 1'b0;
            if (rd_pend_q) begin
                buf_q       <= fifo_data_i;
                buf_valid_q <= 1'b1;
                idx_q       <= '0;
            end else if (consume) begin
                idx_q <= idx_q + 2'd1;
                if (last_byte) buf_valid_q <= 1'b0;
            end
            if (!stall) begin
                tag_valid_q <= 1'b0;
                val_valid_q <= 1'b0;
                val_last_q  <= 1'b0;
                msg_end_q   <= 1'b0;
            end
            if (consume) begin
                case (state_q)
                    S_TAG: begin
                        if (is_digit && !tag_ovf) begin
                            acc_q        <= acc_mul[TAG_WIDTH-1:0];
                            seen_digit_q <= 1'b1;
                        end else if (cur_byte == EQ && seen_digit_q) begin
                            tag_valid_q  <= 1'b1;
                            tag_q        <= acc_q;
                            cur_tag_q    <= acc_q;
                            acc_q        <= '0;
                            seen_digit_q <= 1'b0;
                            held_valid_q <= 1'b0;
                            cnt_q        <= '0;
                            state_q      <= S_VAL;
                        end else begin
                            err_q        <= 1'b1;
                            acc_q        <= '0;
                            seen_digit_q <= 1'b0;
                            state_q      <= (cur_byte == SOH) ? S_TAG : S_ERR;
                        end
                    end
                    S_VAL: begin
                        if (cur_byte == SOH) begin
                            if (held_valid_q) begin
                                val_valid_q <= 1'b1;
                                val_data_q  <= held_q;
                                val_last_q  <= 1'b1;
                                msg_end_q   <= (cur_tag_q == TAG_WIDTH'(10));
                            end else begin
                                err_q <= 1'b1;
                            end
                            held_valid_q <= 1'b0;
                            state_q      <= S_TAG;
                        end else if (cnt_q == CNT_W'(MAX_VAL_LEN)) begin
                            err_q        <= 1'b1;
                            held_valid_q <= 1'b0;
                            state_q      <= S_ERR;
                        end else begin
                            // Holdback: a byte is only released once we know it is not the last.
                            if (held_valid_q) begin
                                val_valid_q <= 1'b1;
                                val_data_q  <= held_q;
                            end
                            held_q       <= cur_byte;
                            held_valid_q <= 1'b1;
                            cnt_q        <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_ERR: begin
                        if (cur_byte == SOH) state_q <= S_TAG;
                    end
                    default: state_q <= S_TAG;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fix_field_tokenizer.sv
// Bench for fix_field_tokenizer: FIFO model feeding byte streams, field-level reference parser,
// observed beats compared event-by-event.
module tb_fix_field_tokenizer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fifo_empty_i = 1'b1;
    logic [31:0] fifo_data_i = '0;
    logic        fifo_rd_en_o, fifo_rd_cs_o;
    logic        out_ready_i = 1'b1;
    logic        tag_valid_o, val_valid_o, val_last_o, msg_end_o, err_o;
    logic [15:0] tag_o;
    logic [7:0]  val_data_o;

    int vectors = 0;
    int miscompares = 0;
    int pop_count = 0;
    int proto_err = 0;
    logic [31:0] fifo_q[$];
    logic [7:0]  stream_b[$];
    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];

    always #5 clk = ~clk;

    fix_field_tokenizer #(.DATA_WIDTH(32), .TAG_WIDTH(16), .MAX_VAL_LEN(256)) dut (
        .clk(clk), .rst(rst), .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
        .fifo_rd_en_o(fifo_rd_en_o), .fifo_rd_cs_o(fifo_rd_cs_o), .out_ready_i(out_ready_i),
        .tag_valid_o(tag_valid_o), .tag_o(tag_o), .val_valid_o(val_valid_o),
        .val_data_o(val_data_o), .val_last_o(val_last_o), .msg_end_o(msg_end_o), .err_o(err_o)
    );

    // FIFO with one-cycle read latency
    always @(posedge clk) begin
        if (fifo_rd_en_o && fifo_q.size() > 0) begin
            fifo_data_i <= fifo_q.pop_front();
            pop_count++;
        end
        fifo_empty_i <= (fifo_q.size() == 0);
    end

    // '|' stands for SOH in these strings
    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++)
            stream_b.push_back((s[i] == 8'h7C) ? 8'h01 : s[i]);
    endtask

    task automatic add_field(input int tag, input int vlen);
        add_str($sformatf("%0d=", tag));
        repeat (vlen) stream_b.push_back(8'($urandom_range(32, 126)));
        stream_b.push_back(8'h01);
    endtask

    // Reference: every SOH closes a field; a field is judged as a whole.
    task automatic model_stream();
        logic [7:0] f[$];
        foreach (stream_b[i]) begin
            if (stream_b[i] != 8'h01) begin
                f.push_back(stream_b[i]);
            end else begin
                int eq = -1;
                bit ok;
                longint t = 0;
                int vlen;
                for (int j = 0; j < f.size(); j++) if (f[j] == 8'h3D) begin eq = j; break; end
                ok = (eq > 0);
                for (int j = 0; j < eq && ok; j++) begin
                    if (f[j] < 8'h30 || f[j] > 8'h39) ok = 0;
                    else begin
                        t = t * 10 + longint'(f[j] - 8'h30);
                        if (t > 65535) ok = 0;
                    end
                end
                if (!ok) exp_q.push_back({2'd3, 18'h0});
                else begin
                    exp_q.push_back({2'd1, 2'b00, t[15:0]});
                    vlen = f.size() - eq - 1;
                    if (vlen == 0) exp_q.push_back({2'd3, 18'h0});
                    else if (vlen > 256) begin
                        for (int k = 0; k < 255; k++) exp_q.push_back({2'd2, 2'b00, 8'h00, f[eq+1+k]});
                        exp_q.push_back({2'd3, 18'h0});
                    end else begin
                        for (int k = 0; k < vlen; k++)
                            exp_q.push_back({2'd2, (k == vlen-1) && (t == 10), k == vlen-1, 8'h00, f[eq+1+k]});
                    end
                end
                f.delete();
            end
        end
    endtask

    task automatic push_stream();
        while (stream_b.size() % 4 != 0) stream_b.push_back(8'h01);
        model_stream();
        for (int i = 0; i < stream_b.size(); i += 4)
            fifo_q.push_back({stream_b[i], stream_b[i+1], stream_b[i+2], stream_b[i+3]});
        stream_b.delete();
    endtask

    task automatic drain(input int budget, input bit rand_ready, input bit stop_at_val, output bit timed_out);
        int idle = 0;
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (tag_valid_o && val_valid_o) proto_err++;
            if (fifo_rd_cs_o !== fifo_rd_en_o) proto_err++;
            if (stop_at_val && val_valid_o) begin
                out_ready_i = 1'b0;
                timed_out = 1'b0;
                return;
            end
            out_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (tag_valid_o && out_ready_i) obs_q.push_back({2'd1, 2'b00, tag_o});
            if (val_valid_o && out_ready_i) obs_q.push_back({2'd2, msg_end_o, val_last_o, 8'h00, val_data_o});
            if (err_o) obs_q.push_back({2'd3, 18'h0});
            if (fifo_q.size() == 0 && !fifo_rd_en_o && !tag_valid_o && !val_valid_o && !err_o) idle++;
            else idle = 0;
            if (idle >= 10 && !stop_at_val) begin
                timed_out = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        bit to;
        obs_q.delete(); exp_q.delete();
        rst = 1'b0;
        add_str("35=A|");
        push_stream();
        repeat (3) @(negedge clk);
        vectors++;
        if ({fifo_rd_en_o, fifo_rd_cs_o, tag_valid_o, tag_o, val_valid_o, val_data_o,
             val_last_o, msg_end_o, err_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got rd=%b tv=%b tag=%0d vv=%b data=%h err=%b want all 0",
                     fifo_rd_en_o, tag_valid_o, tag_o, val_valid_o, val_data_o, err_o);
        end
        rst = 1'b1;
        drain(2000, 1'b0, 1'b0, to);
        vectors++;
        if (to || obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL reset_first_msg events got %0d want %0d timeout=%b", obs_q.size(), exp_q.size(), to);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL reset_first_msg ev%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
            $display("reset_first_msg ev%0d got %h want %h", i, obs_q[i], exp_q[i]);
        end
    endtask

    task automatic test_directed();
        bit to;
        obs_q.delete(); exp_q.delete();
        add_str("10=123|3X=1|8=F|99999=1|58=|");
        push_stream();
        drain(4000, 1'b0, 1'b0, to);
        vectors++;
        if (to || obs_q.size() != exp_q.size() || proto_err != 0) begin
            miscompares++;
            $display("FAIL directed events got %0d want %0d timeout=%b proto=%0d",
                     obs_q.size(), exp_q.size(), to, proto_err);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL directed ev%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
            $display("directed ev%0d got %h want %h", i, obs_q[i], exp_q[i]);
        end
    endtask

    task automatic test_stall();
        bit to;
        logic [33:0] snap;
        int pops;
        obs_q.delete(); exp_q.delete();
        add_str("10=123456|");
        push_stream();
        drain(2000, 1'b0, 1'b1, to);
        snap = {tag_valid_o, tag_o, val_valid_o, val_data_o, val_last_o, msg_end_o, err_o};
        pops = pop_count;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if ({tag_valid_o, tag_o, val_valid_o, val_data_o, val_last_o, msg_end_o, err_o} !== snap
                || fifo_rd_en_o !== 1'b0 || pop_count != pops || to) begin
                miscompares++;
                $display("FAIL stall_hold cyc%0d got out=%h rd=%b pops=%0d want out=%h rd=0 pops=%0d",
                         c, {tag_valid_o, tag_o, val_valid_o, val_data_o, val_last_o, msg_end_o, err_o},
                         fifo_rd_en_o, pop_count, snap, pops);
            end
            $display("stall_hold cyc%0d out=%h rd=%b", c, snap, fifo_rd_en_o);
        end
        drain(4000, 1'b0, 1'b0, to);
        vectors++;
        if (to || obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL stall_stream events got %0d want %0d timeout=%b", obs_q.size(), exp_q.size(), to);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL stall_stream ev%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
            $display("stall_stream ev%0d got %h want %h", i, obs_q[i], exp_q[i]);
        end
    endtask

    task automatic test_random();
        bit to;
        int kind;
        obs_q.delete(); exp_q.delete();
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0: begin add_str("4X="); add_field(7, 2); end
                1: add_field($urandom_range(65536, 99999), 2);
                2: add_field($urandom_range(1, 500), 0);
                3: add_field($urandom_range(1, 500), $urandom_range(256, 257));
                4: add_field(10, $urandom_range(1, 4));
                default: add_field($urandom_range(0, 65535), $urandom_range(1, 6));
            endcase
        end
        push_stream();
        drain(40000, 1'b1, 1'b0, to);
        out_ready_i = 1'b1;
        vectors++;
        if (to || obs_q.size() != exp_q.size() || proto_err != 0) begin
            miscompares++;
            $display("FAIL random events got %0d want %0d timeout=%b proto=%0d",
                     obs_q.size(), exp_q.size(), to, proto_err);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL random ev%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        $display("random %0d events compared", exp_q.size());
    endtask

    task automatic test_reset_mid();
        bit to;
        obs_q.delete(); exp_q.delete();
        add_str("10=12345678|");
        push_stream();
        drain(2000, 1'b0, 1'b1, to);
        out_ready_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if ({fifo_rd_en_o, tag_valid_o, tag_o, val_valid_o, val_data_o, val_last_o, msg_end_o, err_o} !== '0
            || to) begin
            miscompares++;
            $display("FAIL reset_mid_outputs got tv=%b vv=%b data=%h rd=%b want all 0 (timeout=%b)",
                     tag_valid_o, val_valid_o, val_data_o, fifo_rd_en_o, to);
        end
        fifo_q.delete();
        obs_q.delete(); exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        add_str("35=A|");
        push_stream();
        drain(2000, 1'b0, 1'b0, to);
        vectors++;
        if (to || obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL reset_mid_fresh events got %0d want %0d timeout=%b", obs_q.size(), exp_q.size(), to);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL reset_mid_fresh ev%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
            $display("reset_mid_fresh ev%0d got %h want %h", i, obs_q[i], exp_q[i]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
